// File: rtl/morse_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : morse_tx_if
// Description : Start/letter request and Morse output bundle for morse_tx.
// Revision    : 1.0 - initial release
// ============================================================================
interface morse_tx_if;
    logic       start;
    logic [2:0] letter;
    logic       led;
    logic       busy;
    logic       done;

    modport master (
        output start,
        output letter,
        input  led,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  letter,
        output led,
        output busy,
        output done
    );
endinterface
`default_nettype wire

// File: rtl/morse_tx.sv
`default_nettype none
// ============================================================================
// Module      : morse_tx
// Description : Sends one of eight letters (A-H) as Morse code on a single line.
// Revision    : 1.0 - initial release
// ============================================================================
module morse_tx #(
    parameter int UNIT_CYCLES = 25000000
) (
    input  wire logic  clock,
    input  wire logic  resetn,
    morse_tx_if.slave  bus
);

    localparam int c_CNT_W = ((3 * UNIT_CYCLES) > 1) ? $clog2(3 * UNIT_CYCLES) : 1;

    localparam logic [c_CNT_W-1:0] c_UNIT_LAST = c_CNT_W'(UNIT_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_DASH_LAST = c_CNT_W'(3 * UNIT_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ZERO  = '0;
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_MARK  = 2'd1;
    localparam logic [1:0] c_SPACE = 2'd2;

    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [3:0]         r_sym;
    logic [2:0]         r_left;
    logic               r_led;
    logic               r_busy;
    logic               r_done;

    logic [3:0]         w_code_sym;
    logic [2:0]         w_code_len;
    logic               w_mark_end;
    logic               w_space_end;

    // Patterns are left-justified: bit 3 is the first symbol, 1 = dash.
    always_comb begin
        w_code_sym = 4'b0000;
        w_code_len = 3'd1;
        case (bus.letter)
            3'd0: begin w_code_sym = 4'b0100; w_code_len = 3'd2; end
            3'd1: begin w_code_sym = 4'b1000; w_code_len = 3'd4; end
            3'd2: begin w_code_sym = 4'b1010; w_code_len = 3'd4; end
            3'd3: begin w_code_sym = 4'b1000; w_code_len = 3'd3; end
            3'd4: begin w_code_sym = 4'b0000; w_code_len = 3'd1; end
            3'd5: begin w_code_sym = 4'b0010; w_code_len = 3'd4; end
            3'd6: begin w_code_sym = 4'b1100; w_code_len = 3'd3; end
            default: begin w_code_sym = 4'b0000; w_code_len = 3'd4; end
        endcase
    end

    assign w_mark_end  = r_sym[3] ? (r_cnt == c_DASH_LAST) : (r_cnt == c_UNIT_LAST);
    assign w_space_end = (r_cnt == c_UNIT_LAST);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= c_IDLE;
            r_cnt   <= c_CNT_ZERO;
            r_sym   <= 4'b0000;
            r_left  <= 3'd0;
            r_led   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    r_cnt <= c_CNT_ZERO;
                    if (bus.start) begin
                        r_state <= c_MARK;
                        r_sym   <= w_code_sym;
                        r_left  <= w_code_len;
                        r_led   <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                c_MARK: begin
                    if (w_mark_end) begin
                        r_cnt  <= c_CNT_ZERO;
                        r_sym  <= {r_sym[2:0], 1'b0};
                        r_left <= r_left - 3'd1;
                        r_led  <= 1'b0;
                        if (r_left > 3'd1) begin
                            r_state <= c_SPACE;
                        end else begin
                            r_state <= c_IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                c_SPACE: begin
                    if (w_space_end) begin
                        r_cnt   <= c_CNT_ZERO;
                        r_state <= c_MARK;
                        r_led   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                    r_cnt   <= c_CNT_ZERO;
                    r_led   <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.led  = r_led;
    assign bus.busy = r_busy;
    assign bus.done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_morse_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_morse_tx
// Description : Directed self-checking bench for morse_tx with UNIT_CYCLES = 4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_morse_tx;

    localparam int c_U = 4;

    logic clk;
    logic resetn;
    int   n_cmp;
    int   n_fail;

    morse_tx_if bus ();

    morse_tx #(.UNIT_CYCLES(c_U)) dut (
        .clock  (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed=%b expected=%b at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Checks one run of constant led level with busy high, one cycle per negedge.
    task automatic seg(input string tag, input logic lvl, input int len);
        for (int i = 0; i < len; i++) begin
            check({tag, "_led"}, bus.led, lvl);
            check({tag, "_busy"}, bus.busy, 1'b1);
            check({tag, "_done"}, bus.done, 1'b0);
            @(negedge clk);
        end
    endtask

    task automatic fire(input logic [2:0] l);
        bus.letter = l;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start  = 1'b0;
    endtask

    task automatic end_letter(input string tag);
        check({tag, "_done_hi"}, bus.done, 1'b1);
        check({tag, "_busy_lo"}, bus.busy, 1'b0);
        check({tag, "_led_lo"}, bus.led, 1'b0);
        @(negedge clk);
        check({tag, "_done_lo"}, bus.done, 1'b0);
        check({tag, "_idle_led"}, bus.led, 1'b0);
    endtask

    initial begin
        n_cmp      = 0;
        n_fail     = 0;
        resetn     = 1'b0;
        bus.start  = 1'b0;
        bus.letter = 3'd0;
        #1;
        check("rst_led", bus.led, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        check("post_rst_done", bus.done, 1'b0);
        check("post_rst_busy", bus.busy, 1'b0);

        // A: .-
        fire(3'd0);
        seg("A_m0", 1'b1, 4);
        seg("A_s0", 1'b0, 4);
        seg("A_m1", 1'b1, 12);
        end_letter("A");

        // E: .
        fire(3'd4);
        seg("E_m0", 1'b1, 4);
        end_letter("E");

        // H: ....
        fire(3'd7);
        for (int k = 0; k < 3; k++) begin
            seg("H_m", 1'b1, 4);
            seg("H_s", 1'b0, 4);
        end
        seg("H_m3", 1'b1, 4);
        end_letter("H");

        // B: -...
        fire(3'd1);
        seg("B_m0", 1'b1, 12);
        for (int k = 0; k < 3; k++) begin
            seg("B_s", 1'b0, 4);
            seg("B_m", 1'b1, 4);
        end
        end_letter("B");

        // C: -.-. with start/letter disturbed in flight
        fire(3'd2);
        bus.letter = 3'd4;
        seg("C_m0", 1'b1, 12);
        bus.start = 1'b1;
        seg("C_s0", 1'b0, 4);
        bus.start = 1'b0;
        seg("C_m1", 1'b1, 4);
        bus.start = 1'b1;
        seg("C_s1", 1'b0, 4);
        bus.start = 1'b0;
        bus.letter = 3'd7;
        seg("C_m2", 1'b1, 12);
        seg("C_s2", 1'b0, 4);
        seg("C_m3", 1'b1, 4);
        end_letter("C");
        for (int k = 0; k < 3; k++) begin
            check("C_no_extra_busy", bus.busy, 1'b0);
            @(negedge clk);
        end

        // E back-to-back with start held high
        bus.letter = 3'd4;
        bus.start  = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            seg("Erep_m", 1'b1, 4);
            check("Erep_done", bus.done, 1'b1);
            check("Erep_gap_led", bus.led, 1'b0);
            if (k == 2) bus.start = 1'b0;
            @(negedge clk);
        end
        check("Erep_stop_led", bus.led, 1'b0);
        check("Erep_stop_busy", bus.busy, 1'b0);
        check("Erep_stop_done", bus.done, 1'b0);

        // Asynchronous reset in the middle of B's first mark
        fire(3'd1);
        seg("Brst_m0", 1'b1, 2);
        #2;
        resetn = 1'b0;
        #1;
        check("arst_led", bus.led, 1'b0);
        check("arst_busy", bus.busy, 1'b0);
        check("arst_done", bus.done, 1'b0);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        check("arst_idle_busy", bus.busy, 1'b0);
        check("arst_idle_done", bus.done, 1'b0);

        // D: -..
        fire(3'd3);
        seg("D_m0", 1'b1, 12);
        seg("D_s0", 1'b0, 4);
        seg("D_m1", 1'b1, 4);
        seg("D_s1", 1'b0, 4);
        seg("D_m2", 1'b1, 4);
        end_letter("D");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
